// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared types and helpers for the ysyx_25030085 load/store unit.
// Holds the FSM state type, RV32 width codes, AXI response codes and request checks.
package ysyx_25030085_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: misaligned = offset[0];
      F3_W:        misaligned = (offset != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic illegal(input logic is_load, input logic is_store,
                                   input logic [2:0] funct3);
    if (is_load == is_store) begin
      illegal = 1'b1;
    end else if (is_load) begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal = 1'b0;
        default:                        illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W: illegal = 1'b0;
        default:          illegal = 1'b1;
      endcase
    end
  endfunction

  // EXOKAY has no meaning on a Lite link, so it is treated as a failure too.
  function automatic logic resp_err(input logic [1:0] resp);
    case (resp)
      OKAY:           resp_err = 1'b0;
      SLVERR, DECERR: resp_err = 1'b1;
      default:        resp_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Byte-lane steering for the LSU: load extraction/extension and store shift/strobes.
// Purely combinational; offset is the low two bits of the byte address.
module ysyx_25030085_lsu_align
  import ysyx_25030085_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] store_in,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  store_strb
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'b0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase

    store_data = store_in << {offset, 3'b000};
    case (funct3)
      F3_B:    store_strb = 4'b0001 << offset;
      F3_H:    store_strb = 4'b0011 << offset;
      default: store_strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Multi-cycle load/store unit: one request at a time over an AXI4-Lite master,
// result returned as a one-cycle writeback pulse with an error flag for traps.
module ysyx_25030085_lsu
  import ysyx_25030085_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t state, state_nxt;

  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              aw_done, w_done;
  logic              acc_err;
  logic [DATA_W-1:0] load_data, store_data;
  logic [3:0]        store_strb;

  assign acc_err = illegal(in_is_load, in_is_store, in_funct3)
                || misaligned(in_funct3, in_addr[1:0]);

  ysyx_25030085_lsu_align u_align (
    .funct3     (req_funct3),
    .offset     (req_addr[1:0]),
    .rdata      (rdata),
    .store_in   (req_wdata),
    .load_data  (load_data),
    .store_data (store_data),
    .store_strb (store_strb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (acc_err)         state_nxt = RESP;
          else if (in_is_load) state_nxt = RD_ADDR;
          else                 state_nxt = WR_REQ;
        end
      end
      RD_ADDR: if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid)  state_nxt = RESP;
      // A channel already done no longer needs its ready; same-cycle pair exits at once.
      WR_REQ:  if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    arvalid   = (state == RD_ADDR);
    rready    = (state == RD_DATA);
    awvalid   = (state == WR_REQ) && !aw_done;
    wvalid    = (state == WR_REQ) && !w_done;
    bready    = (state == WR_RESP);
    out_valid = (state == RESP);
  end

  assign araddr = req_addr;
  assign awaddr = req_addr;
  assign wdata  = store_data;
  assign wstrb  = store_strb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_funct3 <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      out_rdata  <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            req_funct3 <= in_funct3;
            req_addr   <= in_addr;
            req_wdata  <= in_wdata;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            if (acc_err) begin
              out_rdata <= '0;
              out_err   <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
        RD_DATA: begin
          if (rvalid) begin
            out_err   <= resp_err(rresp);
            out_rdata <= resp_err(rresp) ? '0 : load_data;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            out_err   <= resp_err(bresp);
            out_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Scoreboard bench for the LSU: a driver pushes reference-model results, an AXI-Lite
// slave model answers with planned delays/responses, and a monitor checks each out_valid.
module tb_ysyx_25030085_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_err;
  logic [31:0] out_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  ysyx_25030085_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata), .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          kind;   // 0 no bus, 1 read, 2 write
    int          lat;
    int          acc;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0;

  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [3:0]  p_strb;
  logic [1:0]  p_rresp, p_bresp;
  int p_ar_d, p_r_d, p_aw_d, p_w_d, p_b_d;
  bit seen_ar, seen_aw, aw_got, w_got, r_hs, b_hs, inject_stray;
  int ar_cyc, aw_cyc, w_cyc, r_ph, w_ph, r_cnt, b_cnt;
  logic [31:0] last_rdata;
  bit last_err, hold_en;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic exp_t model(input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
      input logic [1:0] rr, input logic [1:0] br,
      input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d);
    exp_t e;
    int size, off;
    bit legal;
    longint v;
    off = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = (ld != st) && (size != 0) && !(st && f3 >= 3'd4);
    e.wdata = '0; e.strb = '0; e.acc = 0;
    if (!legal || (off % size) != 0) begin
      e.rdata = '0; e.err = 1'b1; e.kind = 0; e.lat = 1;
    end else if (ld) begin
      e.kind = 1;
      e.lat  = 3 + ar_d + r_d;
      v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
      if (f3 < 3'd4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      e.rdata = (rr != 2'b00) ? 32'h0 : v[31:0];
      e.err   = (rr != 2'b00);
    end else begin
      e.kind  = 2;
      e.lat   = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
      e.rdata = '0;
      e.err   = (br != 2'b00);
      e.wdata = wd << (8 * off);
      e.strb  = 4'(((1 << size) - 1) << off);
    end
    return e;
  endfunction

  // AXI-Lite slave model: decides ready/valid at negedge for the following posedge.
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    r_ph = 0; w_ph = 0; r_cnt = 0; b_cnt = 0; inject_stray = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        r_ph = 0; w_ph = 0;
      end else begin
        arready = 0;
        case (r_ph)
          0: begin
            rvalid = 0; rresp = 0; rdata = $urandom;
            if (inject_stray) begin
              rvalid = 1; inject_stray = 0;
            end
            if (arvalid) begin
              seen_ar = 1; ar_cyc++;
              chk("araddr", araddr, p_addr);
              if (ar_cyc == p_ar_d + 1) begin
                arready = 1; r_ph = 1; r_cnt = 0;
              end
            end
          end
          1: begin
            if (r_cnt == p_r_d) begin
              rvalid = 1; rdata = p_rdata; rresp = p_rresp; r_hs = rready; r_ph = 2;
            end else r_cnt++;
          end
          default: begin
            if (r_hs) begin
              rvalid = 0; rresp = 0; rdata = $urandom; r_ph = 0;
            end else r_hs = rready;
          end
        endcase

        awready = 0; wready = 0;
        case (w_ph)
          0: begin
            bvalid = 0; bresp = 0;
            if (aw_got) chk("awvalid_after_hs", 32'(awvalid), 32'h0);
            else if (awvalid) begin
              seen_aw = 1; aw_cyc++;
              chk("awaddr", awaddr, p_addr);
              if (aw_cyc == p_aw_d + 1) begin awready = 1; aw_got = 1; end
            end
            if (w_got) chk("wvalid_after_hs", 32'(wvalid), 32'h0);
            else if (wvalid) begin
              seen_aw = 1; w_cyc++;
              chk("wdata", wdata, p_wdata);
              chk("wstrb", 32'(wstrb), 32'(p_strb));
              if (w_cyc == p_w_d + 1) begin wready = 1; w_got = 1; end
            end
            if (aw_got && w_got && (awready || wready)) begin
              w_ph = 1; b_cnt = 0;
            end
          end
          1: begin
            chk("aw_w_valid_in_wr_resp", 32'({awvalid, wvalid}), 32'h0);
            if (b_cnt == p_b_d) begin
              bvalid = 1; bresp = p_bresp; b_hs = bready; w_ph = 2;
            end else b_cnt++;
          end
          default: begin
            if (b_hs) begin
              bvalid = 0; bresp = 0; w_ph = 0;
            end else b_hs = bready;
          end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every out_valid, checks result holding otherwise.
  initial begin
    exp_t e;
    int obs_kind;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out_valid actual=1 required=0");
          end else begin
            e = sb.pop_front();
            obs_kind = (seen_aw ? 2 : 0) + (seen_ar ? 1 : 0);
            chk("out_rdata", out_rdata, e.rdata);
            chk("out_err", 32'(out_err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("bus_kind", 32'(obs_kind), 32'(e.kind));
            if (e.kind == 1) chk("arvalid_cycles", 32'(ar_cyc), 32'(p_ar_d + 1));
            if (e.kind == 2) begin
              chk("awvalid_cycles", 32'(aw_cyc), 32'(p_aw_d + 1));
              chk("wvalid_cycles", 32'(w_cyc), 32'(p_w_d + 1));
            end
            last_rdata = e.rdata;
            last_err   = e.err;
          end
        end else if (hold_en) begin
          chk("hold_rdata", out_rdata, last_rdata);
          chk("hold_err", 32'(out_err), 32'(last_err));
        end
      end
    end
  end

  task automatic recover();
    #2 rst = 1;
    sb.delete();
    last_rdata = '0; last_err = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
  endtask

  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
      input logic [1:0] rr, input logic [1:0] br,
      input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_timeout("in_ready");
      recover();
      @(negedge clk);
    end
    e = model(ld, st, f3, addr, wd, rd, rr, br, ar_d, r_d, aw_d, w_d, b_d);
    e.acc = cyc + 1;
    p_addr = addr; p_wdata = e.wdata; p_strb = e.strb; p_rdata = rd;
    p_rresp = rr; p_bresp = br;
    p_ar_d = ar_d; p_r_d = r_d; p_aw_d = aw_d; p_w_d = w_d; p_b_d = b_d;
    seen_ar = 0; seen_aw = 0; ar_cyc = 0; aw_cyc = 0; w_cyc = 0; aw_got = 0; w_got = 0;
    sb.push_back(e);
    in_valid = 1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wd;
    @(negedge clk);
    in_valid = 0; in_is_load = 1'($urandom); in_is_store = 1'($urandom);
    in_funct3 = 3'($urandom); in_addr = $urandom; in_wdata = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_timeout("response");
      recover();
    end
  endtask

  task automatic run(input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
      input logic [1:0] rr, input logic [1:0] br,
      input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d);
    issue(ld, st, f3, addr, wd, rd, rr, br, ar_d, r_d, aw_d, w_d, b_d);
    wait_done();
  endtask

  task automatic reset_mid_read();
    int n;
    issue(1, 0, 3'b010, 32'h8000_0010, 32'h0, 32'h1234_5678, 2'b00, 2'b00, 0, 6, 0, 0, 0);
    n = 0;
    while (!rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rready) fail_timeout("rd_data_reached");
    #2 rst = 1;
    #1;
    chk("rst_mid_rready", 32'(rready), 32'h0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'h1);
    chk("rst_mid_arvalid", 32'(arvalid), 32'h0);
    sb.delete();
    last_rdata = '0; last_err = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    inject_stray = 1;
    repeat (4) @(negedge clk);
    chk("stray_rvalid_idle", 32'(in_ready), 32'h1);
    run(1, 0, 3'b100, 32'h8000_0021, 32'h0, 32'h0000_C300, 2'b00, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
    in_addr = 0; in_wdata = 0; hold_en = 0; last_rdata = 0; last_err = 0;
    seen_ar = 0; seen_aw = 0; aw_got = 0; w_got = 0; ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
    p_addr = 0; p_wdata = 0; p_rdata = 0; p_strb = 0; p_rresp = 0; p_bresp = 0;
    p_ar_d = 0; p_r_d = 0; p_aw_d = 0; p_w_d = 0; p_b_d = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready, out_valid}), 32'h0);
    chk("rst_out_rdata", out_rdata, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);
    #2 rst = 0;
    hold_en = 1;

    run(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run(0, 1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 2'b00, 2'b00, 0, 0, 2, 0, 0);
    run(1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run(0, 1, 3'b010, 32'h1000_0000, 32'h5555_AAAA, 32'h0, 2'b00, 2'b10, 0, 0, 0, 0, 0);
    run(1, 0, 3'b010, 32'h1000_0004, 32'h0, 32'hCAFE_F00D, 2'b11, 2'b00, 0, 0, 0, 0, 0);
    run(0, 1, 3'b000, 32'h2000_0003, 32'h1234_56A5, 32'h0, 2'b00, 2'b00, 0, 0, 0, 3, 1);
    reset_mid_read();

    for (int i = 0; i < 120; i++) begin
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      logic [1:0] rr, br;
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) begin ld = 1; st = 1; end
      else if (sel == 1) begin ld = 0; st = 0; end
      else begin ld = (sel % 2) == 0; st = !ld; end
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      end
      rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run(ld, st, f3, a, $urandom, $urandom, rr, br,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25030085_lsu.md
Name: ysyx_25030085_lsu

Overview:
Multi-cycle load/store unit between the execute stage and the register-file writeback. It takes one memory request at a time from the execute stage. It runs the request over an AXI4-Lite master port, then returns the sign- or zero-extended load result, or the store completion, as a one-cycle writeback pulse. That result is the memory-data source for register writeback. Misaligned accesses and bus error responses are reported through an error flag for the trap logic.

Parameters:
ADDR_W, 32, address width for request and bus
DATA_W, 32, data width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  execute stage presents a request
in_ready  out  1  LSU can accept a request (high only in IDLE)
in_is_load  in  1  request is a load
in_is_store  in  1  request is a store
in_funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
in_addr  in  32  effective byte address (ALU result)
in_wdata  in  32  store data (rs2)
out_valid  out  1  one-cycle pulse, result ready
out_rdata  out  32  extended load data (0 for stores and errors)
out_err  out  1  misaligned, illegal or bus-error; qualified by out_valid
araddr  out  32  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  lane-shifted write data
wstrb  out  4  byte strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (async, rst=1): state IDLE; all valid/ready outputs 0 except in_ready=1; out_rdata=0, out_err=0; latched request cleared. Reset mid-transaction abandons it immediately. No pending handshake is completed.
- Accept: when in_valid && in_ready, latch is_load, is_store, funct3, addr and wdata. Inputs are don't-care afterwards.
- Request classification (at acceptance):
  - Misaligned: h/hu/sh with addr[0]!=0; w/sw with addr[1:0]!=0.
  - Illegal: both is_load and is_store set; neither set; or undefined funct3 (loads 011/11x, stores other than 000/001/010).
  - Misaligned or illegal: no bus activity; go to RESP with err=1.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
  - IDLE -> RD_ADDR (load), WR_REQ (store), or RESP (error).
  - RD_ADDR: arvalid=1, araddr=latched addr. On arready, go to RD_DATA.
  - RD_DATA: rready=1. On rvalid, capture the extended data; err=(rresp!=0); go to RESP.
  - WR_REQ: awvalid and wvalid are both raised on entry. Each drops independently after its own handshake (tracked by aw_done and w_done). When both are done, go to WR_RESP. A same-cycle awready and wready pair goes directly to WR_RESP.
  - WR_RESP: bready=1. On bvalid, err=(bresp!=0); go to RESP.
  - RESP: out_valid=1 for exactly one cycle; next state IDLE.
- Latency: with zero-wait slaves, a load is accept in cycle 0, AR handshake in cycle 1, R in cycle 2, out_valid in cycle 3. A store is the same (AW/W in cycle 1, B in cycle 2, out_valid in cycle 3). An error returns out_valid in cycle 1. There is no back-to-back overlap; in_ready returns in the cycle after RESP.
- Valid stability: once raised, arvalid, awvalid and wvalid, with their address/data/strobes, stay stable until the handshake.
- Load extraction: shift rdata right by addr[1:0]*8.
  - b: sign-extend [7:0]; bu: zero-extend [7:0].
  - h: sign-extend [15:0]; hu: zero-extend [15:0].
  - w: pass through.
  - On rresp error, out_rdata=0.
- Store lanes: wdata = in_wdata << addr[1:0]*8; wstrb = sb 4'b0001<<off, sh 4'b0011<<off, sw 4'b1111.
- Bus addresses carry the full byte address, not word-aligned.
- out_rdata and out_err hold their values until the next RESP.

Decomposition:
- Package ysyx_25030085_lsu_pkg:
  - State enum.
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - AXI resp constants (OKAY=00, SLVERR=10, DECERR=11).
  - Misalignment check function.
- Sub-module ysyx_25030085_lsu_align (combinational):
  - Load path: funct3, offset and rdata produce the extended data.
  - Store path: funct3, offset and wdata produce the shifted wdata and wstrb.

Test Plan:
- lb at 0x8000_0003, slave returns rdata=0x80FF_FF7F with zero wait -> wdata unused; out_valid in cycle 3, out_rdata=0xFFFF_FF80, out_err=0.
- lhu at 0x8000_0002, rdata=0xBEEF_1234 -> out_rdata=0x0000_BEEF. Same with lh -> 0xFFFF_BEEF.
- sh at 0x8000_0002, in_wdata=0x0000_ABCD, awready delayed 3 cycles, wready immediate -> wdata=0xABCD_0000, wstrb=4'b1100; wvalid drops after 1 cycle, awvalid held 3 cycles; bready then out_valid, out_err=0.
- lw at 0x8000_0001 -> no arvalid ever; out_valid in cycle 1, out_err=1, out_rdata=0.
- sw at 0x1000_0000 with bresp=2'b10 -> out_err=1. lw with rresp=2'b11 -> out_err=1, out_rdata=0.
- Assert rst while in RD_DATA (arvalid already handshaken, rvalid pending) -> the same cycle gives rready=0, out_valid=0, in_ready=1. A later stray rvalid is ignored, and the next request completes normally.
